// File: rtl/vcxo_discipline_loop.sv
// VCXO frequency-discipline loop: gated VCXO/TCXO counter, tiered step controller, pump output.
// Define VCXO_PWM_SIGMA_DELTA_EN to replace the PWM pump with a first-order sigma-delta modulator.
module vcxo_discipline_loop #(
  parameter int unsigned REF_GATE    = 1228800,
  parameter int unsigned NOMINAL_CNT = 12288000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ERR_W       = 24,
  parameter int unsigned CORR_W      = 8,
  parameter int unsigned PWM_W       = 16,
  parameter int unsigned PWM_INIT    = 32768,
  parameter int unsigned COARSE_THR  = 50,
  parameter int unsigned FINE_THR    = 10,
  parameter int unsigned STEP_XC     = 250,
  parameter int unsigned STEP_C      = 50,
  parameter int unsigned STEP_F      = 1,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic                     vcxo_clk_in,
  input  logic                     reset_in,
  input  logic                     tcxo_in,
  input  logic                     enable_in,
  input  logic signed [CORR_W-1:0] correction_in,
  output logic signed [ERR_W-1:0]  freq_error,
  output logic                     error_valid,
  output logic                     locked,
  output logic [PWM_W-1:0]         pwm_duty,
  output logic                     pump
);

  localparam int unsigned EW   = CNT_W + 2;
  localparam int unsigned DW   = PWM_W + 34;
  localparam int unsigned LC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]        REF_GATE_C = CNT_W'(REF_GATE);
  localparam logic signed [EW-1:0]    NOM_E      = EW'(NOMINAL_CNT);
  localparam logic signed [EW-1:0]    ERR_MAX    = {{(EW-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [EW-1:0]    ERR_MIN    = {{(EW-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W:0]          COARSE_E   = (ERR_W+1)'(COARSE_THR);
  localparam logic [ERR_W:0]          FINE_E     = (ERR_W+1)'(FINE_THR);
  localparam logic [ERR_W+1:0]        COARSE_D   = (ERR_W+2)'(COARSE_THR);
  localparam logic signed [DW-1:0]    DUTY_MAX   = {{(DW-PWM_W){1'b0}}, {PWM_W{1'b1}}};
  localparam logic [LC_W-1:0]         LOCK_C     = LC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, GATE, CALC, TUNE} state_t;
  state_t state, state_nx;

  logic [2:0]              tsync;
  logic                    ref_edge;
  logic [CNT_W-1:0]        vcnt, rcnt;
  logic signed [ERR_W-1:0] prev;
  logic signed [ERR_W:0]   diff;
  logic [LC_W-1:0]         lcnt;
  logic                    first;

  logic signed [EW-1:0]    v_ext, c_ext, err_raw;
  logic signed [ERR_W-1:0] err_sat;
  logic signed [ERR_W:0]   e_ext;
  logic signed [ERR_W+1:0] d_ext2;
  logic [ERR_W:0]          abs_err;
  logic [ERR_W+1:0]        abs_diff;
  logic                    unlock, locked_eff, step_ok;
  logic [31:0]             step;
  logic signed [DW-1:0]    duty_ext, step_ext, duty_sum;
  logic [PWM_W-1:0]        duty_nx;
  logic                    locked_nx;
  logic [LC_W-1:0]         lcnt_nx;

  // Pin edge reaches ref_edge three clocks later: two sync stages plus a registered detect.
  always_ff @(posedge vcxo_clk_in or posedge reset_in) begin
    if (reset_in) begin
      tsync    <= '0;
      ref_edge <= 1'b0;
    end else begin
      tsync    <= {tsync[1:0], tcxo_in};
      ref_edge <= tsync[1] & ~tsync[2];
    end
  end

  always_ff @(posedge vcxo_clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable_in && ref_edge) state_nx = GATE;
      GATE:    if (!enable_in) state_nx = IDLE;
               else if (rcnt == REF_GATE_C) state_nx = CALC;
      CALC:    state_nx = TUNE;
      TUNE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    v_ext   = {2'b00, vcnt};
    c_ext   = EW'(correction_in);
    err_raw = v_ext - NOM_E + c_ext;
    if (err_raw > ERR_MAX)      err_sat = ERR_MAX[ERR_W-1:0];
    else if (err_raw < ERR_MIN) err_sat = ERR_MIN[ERR_W-1:0];
    else                        err_sat = err_raw[ERR_W-1:0];

    e_ext    = {freq_error[ERR_W-1], freq_error};
    abs_err  = e_ext[ERR_W] ? -e_ext : e_ext;
    d_ext2   = {diff[ERR_W], diff};
    abs_diff = d_ext2[ERR_W+1] ? -d_ext2 : d_ext2;

    // Unlock takes effect before step selection so the same TUNE cycle can apply a coarse step.
    unlock     = locked && (abs_err > FINE_E);
    locked_eff = locked && !unlock;
    step_ok    = (diff == '0) || (!locked_eff && (abs_diff < COARSE_D));

    step = '0;
    if (step_ok) begin
      if ((abs_err > COARSE_E) && !locked_eff) step = STEP_XC;
      else if (abs_err > FINE_E)               step = STEP_C;
      else if (abs_err != '0)                  step = STEP_F;
    end
    duty_ext = DW'(pwm_duty);
    step_ext = DW'(step);
    duty_sum = freq_error[ERR_W-1] ? duty_ext + step_ext : duty_ext - step_ext;
    if (duty_sum[DW-1])           duty_nx = '0;
    else if (duty_sum > DUTY_MAX) duty_nx = '1;
    else                          duty_nx = duty_sum[PWM_W-1:0];

    locked_nx = locked;
    lcnt_nx   = lcnt;
    if (unlock) begin
      locked_nx = 1'b0;
      lcnt_nx   = '0;
    end else if ((freq_error == '0) && (diff == '0)) begin
      if (lcnt != LOCK_C) lcnt_nx = lcnt + LC_W'(1);
      if (lcnt_nx == LOCK_C) locked_nx = 1'b1;
    end else begin
      lcnt_nx = '0;
    end
  end

  always_ff @(posedge vcxo_clk_in or posedge reset_in) begin
    if (reset_in) begin
      vcnt        <= '0;
      rcnt        <= '0;
      freq_error  <= '0;
      error_valid <= 1'b0;
      diff        <= '0;
      prev        <= '0;
      locked      <= 1'b0;
      lcnt        <= '0;
      first       <= 1'b1;
      pwm_duty    <= PWM_W'(PWM_INIT);
    end else begin
      error_valid <= 1'b0;
      if (!enable_in) first <= 1'b1;
      case (state)
        IDLE: if (enable_in && ref_edge) begin
          vcnt <= '0;
          rcnt <= '0;
        end
        GATE: if (enable_in && (rcnt != REF_GATE_C)) begin
          if (vcnt != '1) vcnt <= vcnt + CNT_W'(1);
          if (ref_edge)   rcnt <= rcnt + CNT_W'(1);
        end
        CALC: begin
          freq_error  <= err_sat;
          error_valid <= 1'b1;
          diff        <= {prev[ERR_W-1], prev} - {err_sat[ERR_W-1], err_sat};
        end
        TUNE: begin
          prev <= freq_error;
          if (!first) begin
            pwm_duty <= duty_nx;
            locked   <= locked_nx;
            lcnt     <= lcnt_nx;
          end
          if (enable_in) first <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef VCXO_PWM_SIGMA_DELTA_EN
  logic [PWM_W:0] acc;

  always_ff @(posedge vcxo_clk_in or posedge reset_in) begin
    if (reset_in) acc <= '0;
    else          acc <= {1'b0, acc[PWM_W-1:0]} + {1'b0, pwm_duty};
  end

  assign pump = acc[PWM_W];
`else
  logic [PWM_W-1:0] pc, duty_l;

  // Duty is only sampled at the period boundary so a mid-period update cannot glitch the pump.
  always_ff @(posedge vcxo_clk_in or posedge reset_in) begin
    if (reset_in) begin
      pc     <= '0;
      duty_l <= PWM_W'(PWM_INIT);
      pump   <= 1'b0;
    end else begin
      pc   <= pc + PWM_W'(1);
      pump <= (pc < duty_l);
      if (pc == '1) duty_l <= pwm_duty;
    end
  end
`endif

endmodule
